// File: rtl/prince_inv_sbox_cms_pipe.sv
// 2-share CMS-masked PRINCE inverse S-box; PRINCE_SBOX_DIR_SEL_EN adds fwd_i to select the forward S-box.
// Latency 2 cycles, 1 result/cycle; a low out_ready_i freezes both stages and holds the output shares.
module prince_inv_sbox_cms_pipe #(
    parameter bit RST_DATA = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [3:0]  x_sh0_i,
    input  logic [3:0]  x_sh1_i,
    input  logic [31:0] rand_i,
`ifdef PRINCE_SBOX_DIR_SEL_EN
    input  logic        fwd_i,
`endif
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [3:0]  y_sh0_o,
    output logic [3:0]  y_sh1_o
);

    // ANF coefficients of one output bit; index bit3=x, bit2=y, bit1=z, bit0=w.
    function automatic logic [15:0] anf_of(input logic [63:0] tbl, input int k);
        logic [15:0] f;
        for (int m = 0; m < 16; m++) f[4'(m)] = tbl[6'(4 * m + k)];
        for (int i = 0; i < 4; i++)
            for (int m = 0; m < 16; m++)
                if (((m >> i) & 1) == 1) f[4'(m)] = f[4'(m)] ^ f[4'(m ^ (1 << i))];
        return f;
    endfunction

    // Domain d=(a,b,c) picks x share a, y share b, z share c. A monomial containing w
    // borrows the first absent x/y/z variable's domain bit as its w share index, so
    // each share-expanded term of each monomial lands in exactly one domain.
    function automatic logic dom_bit(input logic [15:0] anf, input logic [2:0] d,
                                     input logic [3:0] s0, input logic [3:0] s1);
        logic       acc;
        logic       t;
        logic       ok;
        logic       wsel;
        logic [3:0] mm;
        int         wv;
        acc = anf[0] && (d == 3'd0);
        for (int m = 1; m < 15; m++) begin
            mm   = 4'(m);
            t    = 1'b1;
            ok   = 1'b1;
            wsel = 1'b0;
            wv   = 0;
            if (mm[0]) begin
                for (int v = 1; v < 4; v++) begin
                    if (!mm[2'(v)] && wv == 0) begin
                        wv   = v;
                        wsel = d[2'(v - 1)];
                    end
                end
            end
            for (int v = 1; v < 4; v++) begin
                if (mm[2'(v)]) t = t & (d[2'(v - 1)] ? s1[2'(v)] : s0[2'(v)]);
                else if (v != wv && d[2'(v - 1)]) ok = 1'b0;
            end
            if (mm[0]) t = t & (wsel ? s1[0] : s0[0]);
            if (anf[4'(m)] && ok) acc = acc ^ t;
        end
        return acc;
    endfunction

    localparam logic [63:0] INV_TBL = 64'h1CE5_046A_98DF_237B;
    localparam logic [3:0][15:0] ANF_INV = {anf_of(INV_TBL, 3), anf_of(INV_TBL, 2),
                                            anf_of(INV_TBL, 1), anf_of(INV_TBL, 0)};
`ifdef PRINCE_SBOX_DIR_SEL_EN
    localparam logic [63:0] FWD_TBL = 64'h4D5E_0876_19CA_23FB;
    localparam logic [3:0][15:0] ANF_FWD = {anf_of(FWD_TBL, 3), anf_of(FWD_TBL, 2),
                                            anf_of(FWD_TBL, 1), anf_of(FWD_TBL, 0)};
`endif

    logic            r_v1;
    logic            r_v2;
    logic [3:0][7:0] r_d1;
    logic [3:0]      r_y0;
    logic [3:0]      r_y1;

    logic            w_rdy1;
    logic            w_ld1;
    logic            w_ld2;
    logic [3:0][15:0] w_anf;
    logic [3:0][7:0] w_d1_nxt;
    logic [3:0][7:0] w_e;
    logic [3:0]      w_y0;
    logic [3:0]      w_y1;

    assign w_rdy1      = !r_v2 || out_ready_i;
    assign in_ready_o  = !r_v1 || w_rdy1;
    assign w_ld1       = in_valid_i && in_ready_o;
    assign w_ld2       = r_v1 && w_rdy1;
    assign out_valid_o = r_v2;
    assign y_sh0_o     = r_y0;
    assign y_sh1_o     = r_y1;

    always_comb begin
        w_anf = ANF_INV;
`ifdef PRINCE_SBOX_DIR_SEL_EN
        if (fwd_i) w_anf = ANF_FWD;
`endif
        w_d1_nxt = '0;
        for (int k = 0; k < 4; k++)
            for (int d = 0; d < 8; d++)
                w_d1_nxt[k][d] = dom_bit(w_anf[k], 3'(d), x_sh0_i, x_sh1_i);
    end

    // Ring refresh: every random bit enters two neighbouring domains, so it cancels in the XOR.
    always_comb begin
        logic [7:0] r;
        w_e = '0;
        w_y0 = '0;
        w_y1 = '0;
        for (int k = 0; k < 4; k++) begin
            r = rand_i[8 * k +: 8];
            for (int d = 0; d < 8; d++)
                w_e[k][d] = r_d1[k][d] ^ r[3'(d)] ^ r[3'(d + 7)];
            w_y0[k] = ^w_e[k][3:0];
            w_y1[k] = ^w_e[k][7:4];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            if (w_ld1)       r_v1 <= 1'b1;
            else if (w_rdy1) r_v1 <= 1'b0;
            if (w_ld2)            r_v2 <= 1'b1;
            else if (out_ready_i) r_v2 <= 1'b0;
        end
    end

    if (RST_DATA) begin : g_data_rst
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_d1 <= '0;
                r_y0 <= '0;
                r_y1 <= '0;
            end else begin
                if (w_ld1) r_d1 <= w_d1_nxt;
                if (w_ld2) begin
                    r_y0 <= w_y0;
                    r_y1 <= w_y1;
                end
            end
        end
    end else begin : g_data_norst
        always_ff @(posedge clk) begin
            if (w_ld1) r_d1 <= w_d1_nxt;
            if (w_ld2) begin
                r_y0 <= w_y0;
                r_y1 <= w_y1;
            end
        end
    end

endmodule

// File: tb/tb_prince_inv_sbox_cms_pipe.sv
// Directed bench for the masked PRINCE inverse S-box pipeline.
module tb_prince_inv_sbox_cms_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [3:0]  x_sh0_i;
    logic [3:0]  x_sh1_i;
    logic [31:0] rand_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [3:0]  y_sh0_o;
    logic [3:0]  y_sh1_o;
`ifdef PRINCE_SBOX_DIR_SEL_EN
    logic        fwd_i;
`endif

    always #5 clk = ~clk;

    prince_inv_sbox_cms_pipe dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .x_sh0_i     (x_sh0_i),
        .x_sh1_i     (x_sh1_i),
        .rand_i      (rand_i),
`ifdef PRINCE_SBOX_DIR_SEL_EN
        .fwd_i       (fwd_i),
`endif
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .y_sh0_o     (y_sh0_o),
        .y_sh1_o     (y_sh1_o)
    );

    typedef struct {
        logic [3:0]  sh0;
        logic [3:0]  sh1;
        logic [31:0] rnd;
        logic [3:0]  exp_y;
    } vec_t;

    int         errors = 0;
    int         checks = 0;
    logic [3:0] inv_tbl [16];
    logic [3:0] exp_q [$];
    logic [3:0] mon_exp;
    bit         mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        in_valid_i = 1'b0;
        while (exp_q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    // One isolated transaction with rand_i held; returns the raw output shares.
    task automatic single(input logic [3:0] s0, input logic [3:0] s1, input logic [31:0] rnd,
                          output logic [3:0] o0, output logic [3:0] o1);
        rand_i = rnd;
        x_sh0_i = s0;
        x_sh1_i = s1;
        in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        step();
        chk("single_valid", out_valid_o, 1);
        o0 = y_sh0_o;
        o1 = y_sh1_o;
        step();
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stream_extra: got output 0x%0h with nothing outstanding", y_sh0_o ^ y_sh1_o);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("stream_out", 32'(y_sh0_o ^ y_sh1_o), 32'(mon_exp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [10];
        logic [3:0]  a0, a1, b0, b1, c0, c1, h0, h1;

        inv_tbl = '{4'hB, 4'h7, 4'h3, 4'h2, 4'hF, 4'hD, 4'h8, 4'h9,
                    4'hA, 4'h6, 4'h4, 4'h0, 4'h5, 4'hE, 4'hC, 4'h1};
        vecs[0] = '{4'h3, 4'h0, 32'h0000_0000, 4'h2};
        vecs[1] = '{4'hA, 4'h5, 32'h1234_5678, 4'h1};
        vecs[2] = '{4'h0, 4'h0, 32'hFFFF_FFFF, 4'hB};
        vecs[3] = '{4'hF, 4'hF, 32'hA5A5_5A5A, 4'hB};
        vecs[4] = '{4'h7, 4'h8, 32'h0F0F_F0F0, 4'h1};
        vecs[5] = '{4'hC, 4'h3, 32'hDEAD_BEEF, 4'h1};
        vecs[6] = '{4'h6, 4'h0, 32'h0000_0001, 4'h8};
        vecs[7] = '{4'h2, 4'hB, 32'h8000_0000, 4'h6};
        vecs[8] = '{4'h1, 4'hC, 32'h0808_0808, 4'hE};
        vecs[9] = '{4'hE, 4'h0, 32'h7777_7777, 4'hC};

        rst_n = 1'b0;
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        x_sh0_i = 4'h0;
        x_sh1_i = 4'h0;
        rand_i = 32'h0;
`ifdef PRINCE_SBOX_DIR_SEL_EN
        fwd_i = 1'b0;
`endif
        repeat (3) step();
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_y_sh0", y_sh0_o, 0);
        chk("rst_y_sh1", y_sh1_o, 0);
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", in_ready_o, 1);

        // First transaction: 0x3 appears two cycles after the handshake.
        x_sh0_i = 4'h3;
        x_sh1_i = 4'h0;
        in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
        chk("lat_plus1_valid", out_valid_o, 0);
        step();
        chk("lat_plus2_valid", out_valid_o, 1);
        chk("lat_plus2_data", 32'(y_sh0_o ^ y_sh1_o), 32'h2);
        step();
        chk("lat_plus3_valid", out_valid_o, 0);

        // Hand-computed vector table, streamed back to back.
        mon_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            x_sh0_i = vecs[i].sh0;
            x_sh1_i = vecs[i].sh1;
            rand_i = vecs[i].rnd;
            in_valid_i = 1'b1;
            exp_q.push_back(vecs[i].exp_y);
            step();
        end
        drain();

        // Every share pair, back to back, with random masks.
        for (int i = 0; i < 256; i++) begin
            logic [7:0] p;
            p = 8'(i);
            x_sh0_i = p[7:4];
            x_sh1_i = p[3:0];
            rand_i = $urandom;
            in_valid_i = 1'b1;
            exp_q.push_back(inv_tbl[p[7:4] ^ p[3:0]]);
            if (i == 255) chk("sweep_in_ready", in_ready_o, 1);
            step();
        end
        drain();

        // Back-pressure: two accepted, then the pipe freezes on 0xB.
        out_ready_i = 1'b0;
        x_sh0_i = 4'h0;
        x_sh1_i = 4'h0;
        in_valid_i = 1'b1;
        exp_q.push_back(4'hB);
        step();
        x_sh0_i = 4'h5;
        x_sh1_i = 4'h4;
        exp_q.push_back(4'h7);
        chk("bp_second_ready", in_ready_o, 1);
        step();
        x_sh0_i = 4'h2;
        x_sh1_i = 4'h0;
        chk("bp_in_ready_drop", in_ready_o, 0);
        chk("bp_hold_valid", out_valid_o, 1);
        chk("bp_hold_data", 32'(y_sh0_o ^ y_sh1_o), 32'hB);
        h0 = y_sh0_o;
        h1 = y_sh1_o;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("bp_stall_ready", in_ready_o, 0);
            chk("bp_stall_shares", {y_sh0_o, y_sh1_o}, {h0, h1});
        end
        out_ready_i = 1'b1;
        exp_q.push_back(4'h3);
        step();
        drain();

        // Masks change the shares but never the unmasked result.
        mon_en = 1'b0;
        single(4'h4, 4'h0, 32'h0000_0000, a0, a1);
        single(4'h4, 4'h0, 32'hFFFF_FFFF, b0, b1);
        single(4'h4, 4'h0, 32'h0808_0808, c0, c1);
        chk("rand0_xor", 32'(a0 ^ a1), 32'hF);
        chk("rand1_xor", 32'(b0 ^ b1), 32'hF);
        chk("rand8_xor", 32'(c0 ^ c1), 32'hF);
        chk("rand_allones_cancel", {b0, b1}, {a0, a1});
        chk("rand8_sh0_flip", c0, a0 ^ 4'hF);
        chk("rand8_sh1_flip", c1, a1 ^ 4'hF);

        // Asynchronous reset with both stages full.
        out_ready_i = 1'b0;
        x_sh0_i = 4'h9;
        x_sh1_i = 4'h0;
        in_valid_i = 1'b1;
        step();
        step();
        in_valid_i = 1'b0;
        chk("arst_pre_valid", out_valid_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_immediate_valid", out_valid_o, 0);
        step();
        out_ready_i = 1'b1;
        rst_n = 1'b1;
        step();
        chk("arst_release_ready", in_ready_o, 1);
        for (int c = 0; c < 3; c++) begin
            chk("arst_no_stale", out_valid_o, 0);
            step();
        end

`ifdef PRINCE_SBOX_DIR_SEL_EN
        mon_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            x_sh0_i = (i < 2) ? 4'h0 : 4'h1;
            x_sh1_i = 4'h0;
            fwd_i = (i % 2 == 0);
            rand_i = $urandom;
            in_valid_i = 1'b1;
            step();
        end
        exp_q.push_back(4'hB);
        exp_q.push_back(4'hB);
        exp_q.push_back(4'hF);
        exp_q.push_back(4'h7);
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
